// File: rtl/hit_capture_pkg.sv
// Shared constants and types for the play-mode hit capture stage.
// Module parameters default to the values defined here.
package hit_capture_pkg;

    localparam int NOTE_KEY_BITS   = 7;
    localparam int LENGTH_KEY_BITS = 4;
    localparam int CLOCK_BITS      = 32;
    localparam int OCTAVE_BITS     = 2;
    localparam int NOTE_BITS       = 3;
    localparam int LENGTH_BITS     = 2;
    localparam int OCT_MIN         = 0;
    localparam int OCT_MAX         = 2;
    localparam int OCT_RESET       = 1;
    localparam int DEBOUNCE_CYCLES = 1000000;

    typedef enum logic [1:0] {
        OCT_HOLD,
        OCT_INC,
        OCT_DEC
    } oct_cmd_e;

endpackage

// File: rtl/hit_capture_if.sv
// Valid/ready hit-event channel from the capture stage to the scoring/sound path.
interface hit_if #(
    parameter int CLOCK_BITS  = hit_capture_pkg::CLOCK_BITS,
    parameter int OCTAVE_BITS = hit_capture_pkg::OCTAVE_BITS
);
    import hit_capture_pkg::*;

    logic                   hit_valid;
    logic                   hit_ready;
    logic [OCTAVE_BITS-1:0] hit_octave;
    logic [NOTE_BITS-1:0]   hit_note;
    logic [LENGTH_BITS-1:0] hit_length;
    logic [CLOCK_BITS-1:0]  hit_clock;

    modport master (
        output hit_valid, hit_octave, hit_note, hit_length, hit_clock,
        input  hit_ready
    );

    modport slave (
        input  hit_valid, hit_octave, hit_note, hit_length, hit_clock,
        output hit_ready
    );

endinterface

// File: rtl/hit_capture_key_debounce.sv
// Two-flop synchroniser followed by a per-bit stability debouncer.
// A bit's level flips only after CYCLES consecutive disagreeing samples.
module key_debounce
    import hit_capture_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int CYCLES = DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level
);

    localparam int CNT_BITS = $clog2(CYCLES + 1);
    typedef logic [CNT_BITS-1:0] cnt_t;
    localparam cnt_t CNT_LAST = cnt_t'(CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] level_q, level_d;
    cnt_t             cnt_q [WIDTH];
    cnt_t             cnt_d [WIDTH];

    // Flipping on the last disagreeing sample returns the counter to zero, so it never wraps.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] >= CNT_LAST) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + cnt_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            cnt_q   <= '{default: '0};
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/hit_capture.sv
// Play-mode input stage: debounces note/length/octave keys and turns each
// new note press into one timestamped hit event on a single-entry channel.
module hit_capture #(
    parameter int NOTE_KEY_BITS   = hit_capture_pkg::NOTE_KEY_BITS,
    parameter int LENGTH_KEY_BITS = hit_capture_pkg::LENGTH_KEY_BITS,
    parameter int CLOCK_BITS      = hit_capture_pkg::CLOCK_BITS,
    parameter int OCTAVE_BITS     = hit_capture_pkg::OCTAVE_BITS,
    parameter int OCT_MAX         = hit_capture_pkg::OCT_MAX,
    parameter int OCT_RESET       = hit_capture_pkg::OCT_RESET,
    parameter int DEBOUNCE_CYCLES = hit_capture_pkg::DEBOUNCE_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NOTE_KEY_BITS-1:0]   note_key,
    input  logic [LENGTH_KEY_BITS-1:0] length_key,
    input  logic                       oct_up,
    input  logic                       oct_down,
    input  logic [CLOCK_BITS-1:0]      system_clock,
    hit_if.master                      hit,
    output logic [NOTE_KEY_BITS-1:0]   note_held,
    output logic [OCTAVE_BITS-1:0]     octave,
    output logic                       overrun
);
    import hit_capture_pkg::*;

    logic [NOTE_KEY_BITS-1:0]   note_level, note_prev_q, note_rise;
    logic [LENGTH_KEY_BITS-1:0] len_level, len_prev_q, len_rise;
    logic [1:0]                 oct_level, oct_prev_q, oct_rise;
    logic [OCTAVE_BITS-1:0]     octave_q, octave_d;
    logic [LENGTH_BITS-1:0]     length_q, length_d;
    logic [NOTE_BITS-1:0]       new_note;
    oct_cmd_e                   oct_cmd;
    logic                       accept;

    logic                   hit_valid_q, hit_valid_d;
    logic [OCTAVE_BITS-1:0] hit_octave_q, hit_octave_d;
    logic [NOTE_BITS-1:0]   hit_note_q, hit_note_d;
    logic [LENGTH_BITS-1:0] hit_length_q, hit_length_d;
    logic [CLOCK_BITS-1:0]  hit_clock_q, hit_clock_d;
    logic                   overrun_q, overrun_d;

    key_debounce #(.WIDTH(NOTE_KEY_BITS), .CYCLES(DEBOUNCE_CYCLES)) u_note_db (
        .clk(clk), .rst(rst), .raw(note_key), .level(note_level)
    );

    key_debounce #(.WIDTH(LENGTH_KEY_BITS), .CYCLES(DEBOUNCE_CYCLES)) u_length_db (
        .clk(clk), .rst(rst), .raw(length_key), .level(len_level)
    );

    key_debounce #(.WIDTH(2), .CYCLES(DEBOUNCE_CYCLES)) u_oct_db (
        .clk(clk), .rst(rst), .raw({oct_up, oct_down}), .level(oct_level)
    );

    // Rises come from registered levels, so an event sees octave/length before this cycle's update.
    always_comb begin
        note_rise = note_level & ~note_prev_q;
        len_rise  = len_level & ~len_prev_q;
        oct_rise  = oct_level & ~oct_prev_q;

        new_note = '0;
        for (int i = NOTE_KEY_BITS - 1; i >= 0; i--) begin
            if (note_rise[i]) new_note = NOTE_BITS'(i + 1);
        end

        length_d = length_q;
        for (int i = LENGTH_KEY_BITS - 1; i >= 0; i--) begin
            if (len_rise[i]) length_d = LENGTH_BITS'(i);
        end

        case (oct_rise)
            2'b10:   oct_cmd = OCT_INC;
            2'b01:   oct_cmd = OCT_DEC;
            default: oct_cmd = OCT_HOLD;
        endcase

        octave_d = octave_q;
        case (oct_cmd)
            OCT_INC: if (octave_q < OCTAVE_BITS'(OCT_MAX)) octave_d = octave_q + OCTAVE_BITS'(1);
            OCT_DEC: if (octave_q > OCTAVE_BITS'(OCT_MIN)) octave_d = octave_q - OCTAVE_BITS'(1);
            default: octave_d = octave_q;
        endcase
    end

    always_comb begin
        accept       = hit_valid_q & hit.hit_ready;
        hit_valid_d  = hit_valid_q;
        hit_octave_d = hit_octave_q;
        hit_note_d   = hit_note_q;
        hit_length_d = hit_length_q;
        hit_clock_d  = hit_clock_q;
        overrun_d    = overrun_q;

        if (!en) begin
            hit_valid_d = 1'b0;
            hit_note_d  = '0;
            overrun_d   = 1'b0;
        end else if (new_note != '0) begin
            if (!hit_valid_q || accept) begin
                hit_valid_d  = 1'b1;
                hit_note_d   = new_note;
                hit_octave_d = octave_q;
                hit_length_d = length_q;
                hit_clock_d  = system_clock;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            hit_valid_d = 1'b0;
            hit_note_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            note_prev_q  <= '0;
            len_prev_q   <= '0;
            oct_prev_q   <= '0;
            octave_q     <= OCTAVE_BITS'(OCT_RESET);
            length_q     <= '0;
            hit_valid_q  <= 1'b0;
            hit_octave_q <= '0;
            hit_note_q   <= '0;
            hit_length_q <= '0;
            hit_clock_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            note_prev_q  <= note_level;
            len_prev_q   <= len_level;
            oct_prev_q   <= oct_level;
            octave_q     <= octave_d;
            length_q     <= length_d;
            hit_valid_q  <= hit_valid_d;
            hit_octave_q <= hit_octave_d;
            hit_note_q   <= hit_note_d;
            hit_length_q <= hit_length_d;
            hit_clock_q  <= hit_clock_d;
            overrun_q    <= overrun_d;
        end
    end

    assign hit.hit_valid  = hit_valid_q;
    assign hit.hit_octave = hit_octave_q;
    assign hit.hit_note   = hit_note_q;
    assign hit.hit_length = hit_length_q;
    assign hit.hit_clock  = hit_clock_q;
    assign note_held      = note_level;
    assign octave         = octave_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_hit_capture.sv
// Directed self-checking bench for hit_capture with an 8-cycle debounce window.
module tb_hit_capture;
    import hit_capture_pkg::*;

    localparam int DB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [6:0]  note_key;
    logic [3:0]  length_key;
    logic        oct_up;
    logic        oct_down;
    logic [31:0] sys_clock = '0;
    logic [6:0]  note_held;
    logic [1:0]  octave;
    logic        overrun;

    int          checks = 0;
    int          errors = 0;
    int          ev_count;
    logic [2:0]  ev_note;
    logic [1:0]  ev_oct;
    logic [1:0]  ev_len;
    logic [31:0] ev_clock;
    logic [31:0] ev_first;
    logic [31:0] t0;

    hit_if #(.CLOCK_BITS(32), .OCTAVE_BITS(2)) hit ();

    hit_capture #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .en(en),
        .note_key(note_key), .length_key(length_key),
        .oct_up(oct_up), .oct_down(oct_down),
        .system_clock(sys_clock), .hit(hit),
        .note_held(note_held), .octave(octave), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) sys_clock <= sys_clock + 32'd1;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Records the first event seen over n cycles; outputs are sampled on the falling edge.
    task automatic watch(input int n);
        ev_count = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (hit.hit_valid === 1'b1) begin
                if (ev_count == 0) begin
                    ev_first = sys_clock;
                    ev_note  = hit.hit_note;
                    ev_oct   = hit.hit_octave;
                    ev_len   = hit.hit_length;
                    ev_clock = hit.hit_clock;
                end
                ev_count++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; hit.hit_ready = 1'b1;
        note_key = '0; length_key = '0; oct_up = 1'b0; oct_down = 1'b0;
        wait_cycles(3);
        rst = 1'b0;

        @(negedge clk);
        check_output("rst_valid", hit.hit_valid, 1'b0);
        check_output("rst_note", hit.hit_note, 3'd0);
        check_output("rst_hit_octave", hit.hit_octave, 2'd0);
        check_output("rst_hit_length", hit.hit_length, 2'd0);
        check_output("rst_hit_clock", hit.hit_clock, 32'd0);
        check_output("rst_note_held", note_held, 7'd0);
        check_output("rst_octave", octave, 2'd1);
        check_output("rst_overrun", overrun, 1'b0);
        wait_cycles(1);

        // Single press: event timing and payload
        t0 = sys_clock;
        note_key = 7'b0000100;
        watch(20);
        check_output("t1_count", ev_count, 1);
        check_output("t1_valid_cycle", ev_first, t0 + 32'd11);
        check_output("t1_note", ev_note, 3'd3);
        check_output("t1_octave", ev_oct, 2'd1);
        check_output("t1_length", ev_len, 2'd0);
        check_output("t1_clock", ev_clock, t0 + 32'd10);
        check_output("t1_note_held", note_held, 7'b0000100);
        note_key = '0;
        watch(12);
        check_output("release_no_event", ev_count, 0);

        // Octave saturation and simultaneous up/down
        for (int k = 0; k < 3; k++) begin
            oct_up = 1'b1; wait_cycles(12);
            oct_up = 1'b0; wait_cycles(12);
            @(negedge clk);
            check_output("oct_up_sat", octave, 2'd2);
            wait_cycles(1);
        end
        oct_down = 1'b1; wait_cycles(12);
        oct_down = 1'b0; wait_cycles(12);
        @(negedge clk);
        check_output("oct_down", octave, 2'd1);
        wait_cycles(1);
        oct_up = 1'b1; oct_down = 1'b1; wait_cycles(12);
        oct_up = 1'b0; oct_down = 1'b0; wait_cycles(12);
        @(negedge clk);
        check_output("oct_both", octave, 2'd1);
        wait_cycles(1);

        // Length select, lowest-index note, glitch rejection
        length_key = 4'b0100; wait_cycles(12);
        length_key = 4'b0000; wait_cycles(12);
        note_key = 7'b0000001;
        watch(14);
        check_output("len_count", ev_count, 1);
        check_output("len_note", ev_note, 3'd1);
        check_output("len_length", ev_len, 2'd2);
        note_key = '0; wait_cycles(12);
        note_key = 7'b0000110;
        watch(14);
        check_output("lowest_count", ev_count, 1);
        check_output("lowest_note", ev_note, 3'd2);
        note_key = '0; wait_cycles(12);
        note_key = 7'b0001000; wait_cycles(5);
        note_key = '0;
        watch(15);
        check_output("glitch_count", ev_count, 0);
        check_output("glitch_held", note_held, 7'd0);

        // Backpressure, overrun and accept with coincident new edge
        hit.hit_ready = 1'b0;
        note_key = 7'b0000001; wait_cycles(12);
        @(negedge clk);
        check_output("bp_valid", hit.hit_valid, 1'b1);
        check_output("bp_note", hit.hit_note, 3'd1);
        check_output("bp_overrun0", overrun, 1'b0);
        wait_cycles(1);
        note_key = 7'b0000011; wait_cycles(12);
        @(negedge clk);
        check_output("ovr_valid", hit.hit_valid, 1'b1);
        check_output("ovr_note", hit.hit_note, 3'd1);
        check_output("ovr_flag", overrun, 1'b1);
        wait_cycles(1);
        note_key = 7'b0010011; wait_cycles(10);
        hit.hit_ready = 1'b1;
        @(negedge clk);
        check_output("acc_valid_a", hit.hit_valid, 1'b1);
        check_output("acc_note_a", hit.hit_note, 3'd1);
        wait_cycles(1);
        @(negedge clk);
        check_output("acc_valid_b", hit.hit_valid, 1'b1);
        check_output("acc_note_b", hit.hit_note, 3'd5);
        check_output("acc_overrun", overrun, 1'b1);
        wait_cycles(1);
        @(negedge clk);
        check_output("acc_drained", hit.hit_valid, 1'b0);
        wait_cycles(1);

        // Disable clears pending state; octave keeps running
        note_key = '0; wait_cycles(12);
        hit.hit_ready = 1'b0;
        note_key = 7'b1000000; wait_cycles(12);
        @(negedge clk);
        check_output("en_pending_note", hit.hit_note, 3'd7);
        check_output("en_pending_ovr", overrun, 1'b1);
        wait_cycles(1);
        en = 1'b0;
        wait_cycles(1);
        @(negedge clk);
        check_output("en_off_valid", hit.hit_valid, 1'b0);
        check_output("en_off_note", hit.hit_note, 3'd0);
        check_output("en_off_overrun", overrun, 1'b0);
        wait_cycles(1);
        note_key = 7'b1001000;
        watch(14);
        check_output("en_off_no_event", ev_count, 0);
        check_output("en_off_held", note_held, 7'b1001000);
        oct_down = 1'b1; wait_cycles(12);
        oct_down = 1'b0; wait_cycles(12);
        @(negedge clk);
        check_output("en_off_octave", octave, 2'd0);
        wait_cycles(1);

        // Reset mid-debounce with an event pending
        en = 1'b1;
        note_key = 7'b1101000; wait_cycles(12);
        @(negedge clk);
        check_output("pre_rst_note", hit.hit_note, 3'd6);
        wait_cycles(1);
        oct_up = 1'b1; wait_cycles(5);
        rst = 1'b1; wait_cycles(1);
        rst = 1'b0;
        @(negedge clk);
        check_output("mid_rst_valid", hit.hit_valid, 1'b0);
        check_output("mid_rst_note", hit.hit_note, 3'd0);
        check_output("mid_rst_held", note_held, 7'd0);
        check_output("mid_rst_octave", octave, 2'd1);
        check_output("mid_rst_clock", hit.hit_clock, 32'd0);
        wait_cycles(9);
        @(negedge clk);
        check_output("post_rst_held_early", note_held, 7'd0);
        wait_cycles(1);
        @(negedge clk);
        check_output("post_rst_held", note_held, 7'b1101000);
        wait_cycles(1);
        @(negedge clk);
        check_output("post_rst_valid", hit.hit_valid, 1'b1);
        check_output("post_rst_note", hit.hit_note, 3'd4);
        check_output("post_rst_hit_octave", hit.hit_octave, 2'd1);
        check_output("post_rst_octave", octave, 2'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
